wbu: RTL and testbench

WBU -- requirements
Module: wbu

---
 rtl/wbu.sv | 174 +++++++++++++++++
 tb/tb_wbu.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// Write-back unit: single-entry stage register between LSU and the register files.
// Retires one instruction per cycle; fence.i waits for an I-cache invalidate ack.
module wbu #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5,
    parameter int CSR_ADDRW = 12,
    parameter int INS_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    input  logic [CPU_WIDTH-1:0] i_lsu_lsres,
    input  logic [CPU_WIDTH-1:0] i_lsu_exres,
    input  logic                 i_lsu_lden,
    input  logic                 i_lsu_fencei,
    input  logic [REG_ADDRW-1:0] i_lsu_rdid,
    input  logic                 i_lsu_rdwen,
    input  logic [CSR_ADDRW-1:0] i_lsu_csrdid,
    input  logic                 i_lsu_csrdwen,
    input  logic [CPU_WIDTH-1:0] i_lsu_csrd,
    input  logic [CPU_WIDTH-1:0] i_lsu_pc,
    input  logic [INS_WIDTH-1:0] i_lsu_ins,
    input  logic                 i_lsu_nop,
    output logic                 o_icache_inv_req,
    input  logic                 i_icache_inv_ack,
    output logic                 o_rf_wen,
    output logic [REG_ADDRW-1:0] o_rf_waddr,
    output logic [CPU_WIDTH-1:0] o_rf_wdata,
    output logic                 o_csr_wen,
    output logic [CSR_ADDRW-1:0] o_csr_waddr,
    output logic [CPU_WIDTH-1:0] o_csr_wdata,
    output logic [REG_ADDRW-1:0] o_wbu_rdid,
    output logic                 o_wbu_rdwen,
    output logic                 o_commit,
    output logic [CPU_WIDTH-1:0] o_commit_pc,
    output logic [INS_WIDTH-1:0] o_commit_ins,
    output logic [63:0]          o_instret
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FENCE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CPU_WIDTH-1:0] lsres_q;
    logic [CPU_WIDTH-1:0] exres_q;
    logic                 lden_q;
    logic                 fencei_q;
    logic [REG_ADDRW-1:0] rdid_q;
    logic                 rdwen_q;
    logic [CSR_ADDRW-1:0] csrdid_q;
    logic                 csrdwen_q;
    logic [CPU_WIDTH-1:0] csrd_q;
    logic [CPU_WIDTH-1:0] pc_q;
    logic [INS_WIDTH-1:0] ins_q;
    logic                 nop_q;
    logic [63:0]          instret_q, instret_d;

    logic valid_w;
    logic fire_w;
    logic ready_w;
    logic pre_sh_w;
    logic accept_w;
    logic commit_w;

    assign valid_w  = (state_q != IDLE);
    assign ready_w  = ~valid_w | fire_w;
    assign pre_sh_w = i_pre_valid & ready_w;
    assign accept_w = pre_sh_w & ~i_flush;
    assign commit_w = fire_w & ~nop_q;

    // Retire condition: plain instructions leave at once, fence.i waits for the ack.
    always_comb begin
        fire_w = 1'b0;
        unique case (state_q)
            HOLD:    fire_w = 1'b1;
            FENCE:   fire_w = i_icache_inv_ack;
            default: fire_w = 1'b0;
        endcase
    end

    // Next state: a free slot (empty or retiring) reloads from the LSU offer.
    always_comb begin
        state_d = state_q;
        if (ready_w) begin
            if (accept_w) begin
                state_d = i_lsu_fencei ? FENCE : HOLD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State register; the held instruction's valid bit is encoded in it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage payload; a flushed offer may load but stays invalid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lsres_q   <= '0;
            exres_q   <= '0;
            lden_q    <= 1'b0;
            fencei_q  <= 1'b0;
            rdid_q    <= '0;
            rdwen_q   <= 1'b0;
            csrdid_q  <= '0;
            csrdwen_q <= 1'b0;
            csrd_q    <= '0;
            pc_q      <= '0;
            ins_q     <= '0;
            nop_q     <= 1'b0;
        end else if (pre_sh_w) begin
            lsres_q   <= i_lsu_lsres;
            exres_q   <= i_lsu_exres;
            lden_q    <= i_lsu_lden;
            fencei_q  <= i_lsu_fencei;
            rdid_q    <= i_lsu_rdid;
            rdwen_q   <= i_lsu_rdwen;
            csrdid_q  <= i_lsu_csrdid;
            csrdwen_q <= i_lsu_csrdwen;
            csrd_q    <= i_lsu_csrd;
            pc_q      <= i_lsu_pc;
            ins_q     <= i_lsu_ins;
            nop_q     <= i_lsu_nop;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64.
    always_comb begin
        instret_d = instret_q;
        if (commit_w) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    // Output decode from the held instruction.
    always_comb begin
        o_pre_ready      = ready_w;
        o_icache_inv_req = (state_q == FENCE) & fencei_q;
        o_rf_wen         = commit_w & rdwen_q & (rdid_q != '0);
        o_rf_waddr       = rdid_q;
        o_rf_wdata       = lden_q ? lsres_q : exres_q;
        o_csr_wen        = commit_w & csrdwen_q;
        o_csr_waddr      = csrdid_q;
        o_csr_wdata      = csrd_q;
        o_wbu_rdid       = rdid_q;
        o_wbu_rdwen      = valid_w & rdwen_q & ~nop_q;
        o_commit         = commit_w;
        o_commit_pc      = pc_q;
        o_commit_ins     = ins_q;
        o_instret        = instret_q;
    end

endmodule

// File: tb/tb_wbu.sv
// Directed bench for the write-back unit.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_wbu;

    logic        clk = 1'b0;
    logic        rst, flush, pre_valid, pre_ready;
    logic [63:0] lsres, exres, csrd, pc;
    logic        lden, fencei, rdwen, csrdwen, nop;
    logic [4:0]  rdid;
    logic [11:0] csrdid;
    logic [31:0] ins;
    logic        inv_req, inv_ack;
    logic        rf_wen, csr_wen, wbu_rdwen, commit;
    logic [4:0]  rf_waddr, wbu_rdid;
    logic [63:0] rf_wdata, csr_wdata, commit_pc, instret;
    logic [11:0] csr_waddr;
    logic [31:0] commit_ins;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wbu dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
        .i_lsu_lsres(lsres), .i_lsu_exres(exres),
        .i_lsu_lden(lden), .i_lsu_fencei(fencei),
        .i_lsu_rdid(rdid), .i_lsu_rdwen(rdwen),
        .i_lsu_csrdid(csrdid), .i_lsu_csrdwen(csrdwen),
        .i_lsu_csrd(csrd), .i_lsu_pc(pc), .i_lsu_ins(ins),
        .i_lsu_nop(nop),
        .o_icache_inv_req(inv_req), .i_icache_inv_ack(inv_ack),
        .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr),
        .o_rf_wdata(rf_wdata),
        .o_csr_wen(csr_wen), .o_csr_waddr(csr_waddr),
        .o_csr_wdata(csr_wdata),
        .o_wbu_rdid(wbu_rdid), .o_wbu_rdwen(wbu_rdwen),
        .o_commit(commit), .o_commit_pc(commit_pc),
        .o_commit_ins(commit_ins), .o_instret(instret)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        flush = 0; pre_valid = 0; lsres = 0; exres = 0;
        lden = 0; fencei = 0; rdid = 0; rdwen = 0;
        csrdid = 0; csrdwen = 0; csrd = 0; pc = 0;
        ins = 0; nop = 0; inv_ack = 0;
    endtask

    task automatic do_reset();
        step();
        clear_in();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        step();
        clear_in();
        rst = 1;
        step();
        settle();
        checks++;
        if (pre_ready !== 1'b1 || commit !== 1'b0 || rf_wen !== 1'b0
            || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_in: ready=%b commit=%b wen=%b inv=%b req 1 0 0 0",
                     pre_ready, commit, rf_wen, inv_req);
        end
        rst = 0;
        step();
        settle();
        checks++;
        if (pre_ready !== 1'b1 || instret !== 64'd0 || rf_waddr !== 5'd0
            || rf_wdata !== 64'd0 || csr_wen !== 1'b0 || wbu_rdwen !== 1'b0
            || commit_pc !== 64'd0 || commit_ins !== 32'd0) begin
            failures++;
            $display("FAIL reset_after: ready=%b instret=%0d waddr=%0d wdata=%h req ready=1 rest 0",
                     pre_ready, instret, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pre_valid = 1; rdwen = 1; rdid = 5; exres = 64'h11;
        pc = 64'h1000; ins = 32'h0000_0293;
        settle();
        checks++;
        if (pre_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready0: got %b req 1", pre_ready);
        end
        step();
        rdid = 6; exres = 64'h22; pc = 64'h1004;
        settle();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h11
            || pre_ready !== 1'b1 || commit_pc !== 64'h1000) begin
            failures++;
            $display("FAIL b2b_first: wen=%b addr=%0d data=%h rdy=%b pc=%h req 1 5 11 1 1000",
                     rf_wen, rf_waddr, rf_wdata, pre_ready, commit_pc);
        end
        step();
        clear_in();
        settle();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 64'h22
            || pre_ready !== 1'b1 || instret !== 64'd1) begin
            failures++;
            $display("FAIL b2b_second: wen=%b addr=%0d data=%h rdy=%b ir=%0d req 1 6 22 1 1",
                     rf_wen, rf_waddr, rf_wdata, pre_ready, instret);
        end
        step();
        settle();
        checks++;
        if (rf_wen !== 1'b0 || instret !== 64'd2) begin
            failures++;
            $display("FAIL b2b_end: wen=%b instret=%0d req 0 2", rf_wen, instret);
        end
    endtask

    task automatic test_load();
        do_reset();
        pre_valid = 1; rdwen = 1; rdid = 3; lden = 1;
        lsres = 64'hFFFF_FFFF_FFFF_FF80; exres = 64'h8000_0010;
        step();
        rdid = 0;
        settle();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd3
            || rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80 || commit !== 1'b1) begin
            failures++;
            $display("FAIL load_rd3: wen=%b addr=%0d data=%h commit=%b req 1 3 ffffffffffffff80 1",
                     rf_wen, rf_waddr, rf_wdata, commit);
        end
        step();
        clear_in();
        settle();
        checks++;
        if (rf_wen !== 1'b0 || commit !== 1'b1 || wbu_rdwen !== 1'b1) begin
            failures++;
            $display("FAIL load_rd0: wen=%b commit=%b byp=%b req 0 1 1",
                     rf_wen, commit, wbu_rdwen);
        end
        step();
        settle();
        checks++;
        if (instret !== 64'd2) begin
            failures++;
            $display("FAIL load_instret: got %0d req 2", instret);
        end
    endtask

    task automatic test_fence();
        int req_cycles;
        req_cycles = 0;
        do_reset();
        pre_valid = 1; fencei = 1; rdwen = 1; rdid = 7; exres = 64'h77;
        step();
        fencei = 0; rdid = 8; exres = 64'h88;
        for (int c = 1; c <= 3; c++) begin
            settle();
            if (inv_req === 1'b1) req_cycles++;
            checks++;
            if (inv_req !== 1'b1 || pre_ready !== 1'b0 || commit !== 1'b0
                || rf_wen !== 1'b0 || wbu_rdwen !== 1'b1 || wbu_rdid !== 5'd7) begin
                failures++;
                $display("FAIL fence_wait%0d: inv=%b rdy=%b commit=%b wen=%b byp=%b req 1 0 0 0 1",
                         c, inv_req, pre_ready, commit, rf_wen, wbu_rdwen);
            end
            step();
        end
        inv_ack = 1;
        settle();
        if (inv_req === 1'b1) req_cycles++;
        checks++;
        if (inv_req !== 1'b1 || commit !== 1'b1 || pre_ready !== 1'b1
            || rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'h77) begin
            failures++;
            $display("FAIL fence_ack: inv=%b commit=%b rdy=%b wen=%b addr=%0d req 1 1 1 1 7",
                     inv_req, commit, pre_ready, rf_wen, rf_waddr);
        end
        step();
        clear_in();
        settle();
        if (inv_req === 1'b1) req_cycles++;
        checks++;
        if (inv_req !== 1'b0 || rf_wen !== 1'b1 || rf_waddr !== 5'd8
            || rf_wdata !== 64'h88 || req_cycles != 4) begin
            failures++;
            $display("FAIL fence_next: inv=%b wen=%b addr=%0d reqcyc=%0d req 0 1 8 4",
                     inv_req, rf_wen, rf_waddr, req_cycles);
        end
        step();
        settle();
        checks++;
        if (instret !== 64'd2 || commit !== 1'b0) begin
            failures++;
            $display("FAIL fence_instret: ir=%0d commit=%b req 2 0", instret, commit);
        end
        inv_ack = 1;
        settle();
        checks++;
        if (commit !== 1'b0 || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack: commit=%b inv=%b req 0 0", commit, inv_req);
        end
        inv_ack = 0;
    endtask

    task automatic test_flush();
        do_reset();
        pre_valid = 1; flush = 1; rdwen = 1; rdid = 9; exres = 64'h99;
        step();
        clear_in();
        settle();
        checks++;
        if (commit !== 1'b0 || rf_wen !== 1'b0 || pre_ready !== 1'b1
            || wbu_rdwen !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: commit=%b wen=%b rdy=%b byp=%b req 0 0 1 0",
                     commit, rf_wen, pre_ready, wbu_rdwen);
        end
        pre_valid = 1; csrdwen = 1; csrdid = 12'h300; csrd = 64'h8;
        step();
        clear_in();
        pre_valid = 1; flush = 1; rdwen = 1; rdid = 10;
        settle();
        checks++;
        if (csr_wen !== 1'b1 || csr_waddr !== 12'h300 || csr_wdata !== 64'h8
            || commit !== 1'b1) begin
            failures++;
            $display("FAIL flush_csr: wen=%b addr=%h data=%h commit=%b req 1 300 8 1",
                     csr_wen, csr_waddr, csr_wdata, commit);
        end
        step();
        clear_in();
        settle();
        checks++;
        if (commit !== 1'b0 || csr_wen !== 1'b0 || rf_wen !== 1'b0
            || instret !== 64'd1) begin
            failures++;
            $display("FAIL flush_after: commit=%b cwen=%b wen=%b ir=%0d req 0 0 0 1",
                     commit, csr_wen, rf_wen, instret);
        end
    endtask

    task automatic test_nop();
        do_reset();
        pre_valid = 1; nop = 1; rdwen = 1; rdid = 4;
        csrdwen = 1; csrdid = 12'h305;
        step();
        clear_in();
        settle();
        checks++;
        if (rf_wen !== 1'b0 || csr_wen !== 1'b0 || commit !== 1'b0
            || wbu_rdwen !== 1'b0 || pre_ready !== 1'b1) begin
            failures++;
            $display("FAIL nop: wen=%b cwen=%b commit=%b byp=%b rdy=%b req 0 0 0 0 1",
                     rf_wen, csr_wen, commit, wbu_rdwen, pre_ready);
        end
        step();
        settle();
        checks++;
        if (instret !== 64'd0) begin
            failures++;
            $display("FAIL nop_instret: got %0d req 0", instret);
        end
    endtask

    task automatic test_reset_fence();
        do_reset();
        pre_valid = 1; fencei = 1; rdwen = 1; rdid = 2;
        step();
        clear_in();
        step();
        settle();
        checks++;
        if (inv_req !== 1'b1) begin
            failures++;
            $display("FAIL rf_fence_wait: inv=%b req 1", inv_req);
        end
        rst = 1;
        step();
        rst = 0;
        inv_ack = 1;
        settle();
        checks++;
        if (inv_req !== 1'b0 || commit !== 1'b0 || pre_ready !== 1'b1
            || rf_wen !== 1'b0) begin
            failures++;
            $display("FAIL rf_late_ack: inv=%b commit=%b rdy=%b wen=%b req 0 0 1 0",
                     inv_req, commit, pre_ready, rf_wen);
        end
        step();
        inv_ack = 0;
        settle();
        checks++;
        if (instret !== 64'd0 || commit !== 1'b0 || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL rf_end: ir=%0d commit=%b inv=%b req 0 0 0",
                     instret, commit, inv_req);
        end
    endtask

    initial begin
        rst = 1;
        clear_in();
        test_reset();
        test_back_to_back();
        test_load();
        test_fence();
        test_flush();
        test_nop();
        test_reset_fence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
